// File: rtl/alu_regfile_core.sv
// Register file (x0 tied to zero) feeding a 4-bit-opcode ALU for the single-cycle datapath.
// Reads and the ALU are combinational; writes land at the rising clock edge.

module alu_regfile_reg #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [DATAWIDTH-1:0] d,
  output logic [DATAWIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= '0;
    else if (we) q <= d;
  end
endmodule

module alu_regfile_alu #(
  parameter int DATAWIDTH = 32
) (
  input  logic [DATAWIDTH-1:0] op1,
  input  logic [DATAWIDTH-1:0] op2,
  input  logic [3:0]           alu_op,
  output logic [DATAWIDTH-1:0] result
);
  localparam int SHW = $clog2(DATAWIDTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_XOR = 4'b1101;

  // only the low bits of op2 steer shifts; upper bits are ignored
  logic [SHW-1:0] shamt;
  logic           slt;

  assign shamt = op2[SHW-1:0];
  assign slt   = $signed(op1) < $signed(op2);

  always_comb begin
    result = '0;
    case (alu_op)
      OP_AND:  result = op1 & op2;
      OP_OR:   result = op1 | op2;
      OP_ADD:  result = op1 + op2;
      OP_SUB:  result = op1 - op2;
      OP_SLT:  result = {{(DATAWIDTH-1){1'b0}}, slt};
      OP_SRL:  result = op1 >> shamt;
      OP_SLL:  result = op1 << shamt;
      OP_SRA:  result = $signed(op1) >>> shamt;
      OP_XOR:  result = op1 ^ op2;
      default: result = '0;
    endcase
  end
endmodule

module alu_regfile_core #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 write,
  input  logic [ADDRWIDTH-1:0] readReg1,
  input  logic [ADDRWIDTH-1:0] readReg2,
  input  logic [ADDRWIDTH-1:0] writeReg,
  input  logic [DATAWIDTH-1:0] writeData,
  input  logic                 alu_src,
  input  logic [DATAWIDTH-1:0] imm,
  input  logic [3:0]           alu_op,
  output logic [DATAWIDTH-1:0] readData1,
  output logic [DATAWIDTH-1:0] readData2,
  output logic [DATAWIDTH-1:0] result,
  output logic                 zero
);
  localparam int NREG = 2**ADDRWIDTH;

  logic [NREG-1:0][DATAWIDTH-1:0] regs;
  logic [DATAWIDTH-1:0]           op2;

  // x0 has no storage, so writes to it vanish and reads return zero
  assign regs[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_reg
      logic we;
      assign we = write && (writeReg == ADDRWIDTH'(gi));
      alu_regfile_reg #(.DATAWIDTH(DATAWIDTH)) u_reg (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .d   (writeData),
        .q   (regs[gi])
      );
    end
  endgenerate

  assign readData1 = regs[readReg1];
  assign readData2 = regs[readReg2];
  assign op2       = alu_src ? imm : readData2;

  alu_regfile_alu #(.DATAWIDTH(DATAWIDTH)) u_alu (
    .op1    (readData1),
    .op2    (op2),
    .alu_op (alu_op),
    .result (result)
  );

  assign zero = (result == '0);
endmodule

// File: tb/tb_alu_regfile_core.sv
// Directed plus randomized checks of alu_regfile_core against an arithmetic reference model.

module tb_alu_regfile_core;
  logic        clk = 1'b0;
  logic        rst;
  logic        write;
  logic [4:0]  readReg1, readReg2, writeReg;
  logic [31:0] writeData, imm;
  logic        alu_src;
  logic [3:0]  alu_op;
  logic [31:0] readData1, readData2, result;
  logic        zero;

  int passed = 0;
  int total  = 0;
  logic [31:0] model [32];

  always #5 clk = ~clk;

  alu_regfile_core dut (
    .clk(clk), .rst(rst), .write(write),
    .readReg1(readReg1), .readReg2(readReg2), .writeReg(writeReg),
    .writeData(writeData), .alu_src(alu_src), .imm(imm), .alu_op(alu_op),
    .readData1(readData1), .readData2(readData2), .result(result), .zero(zero)
  );

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, p, sa;
    int     sh;
    ua = longint'(a);
    ub = longint'(b);
    sh = int'(b % 32);
    p  = longint'(1) << sh;
    sa = (a >= 32'h8000_0000) ? ua - (longint'(1) << 32) : ua;
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return 32'((ua + ub) % (longint'(1) << 32));
      4'b0110: return 32'((ua - ub + (longint'(1) << 32)) % (longint'(1) << 32));
      4'b0111: begin
        longint sb;
        sb = (b >= 32'h8000_0000) ? ub - (longint'(1) << 32) : ub;
        return (sa < sb) ? 32'd1 : 32'd0;
      end
      4'b1000: return 32'(ua / p);
      4'b1001: return 32'((ua * p) % (longint'(1) << 32));
      4'b1010: return (sa >= 0) ? 32'(sa / p) : 32'(-((-sa + p - 1) / p));
      4'b1101: return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] data, input logic en);
    @(negedge clk);
    write = en; writeReg = idx; writeData = data;
    @(posedge clk);
    #1;
    if (en && rst && idx != 5'd0) model[idx] = data;
    write = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic src, input logic [31:0] iv, input logic [3:0] op);
    logic [31:0] o2, e;
    readReg1 = rs1; readReg2 = rs2; alu_src = src; imm = iv; alu_op = op;
    #1;
    o2 = src ? iv : model[rs2];
    e  = ref_alu(op, model[rs1], o2);
    chk({tag, ".rd1"}, readData1, model[rs1]);
    chk({tag, ".rd2"}, readData2, model[rs2]);
    chk({tag, ".res"}, result, e);
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, e == 32'd0});
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  initial begin
    logic [3:0] ops [10];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1101, 4'b1111};
    model_clear();
    rst = 1'b0; write = 1'b0; readReg1 = '0; readReg2 = '0; writeReg = '0;
    writeData = '0; alu_src = 1'b0; imm = '0; alu_op = 4'b0010;

    // reset state: zero operands through ADD
    #12;
    rd_check("reset", 5'd3, 5'd31, 1'b0, 32'd0, 4'b0010);
    // writes ignored while in reset
    wr(5'd4, 32'h1234_5678, 1'b1);
    rd_check("rst_wr", 5'd4, 5'd0, 1'b0, 32'd0, 4'b0001);
    @(negedge clk); rst = 1'b1;

    // ADD/SUB with x5/x6
    wr(5'd5, 32'h0000_000A, 1'b1);
    wr(5'd6, 32'hFFFF_FFF6, 1'b1);
    rd_check("add", 5'd5, 5'd6, 1'b0, 32'd0, 4'b0010);
    chk("add_dir", result, 32'd0);
    chk("add_zero", {31'd0, zero}, 32'd1);
    rd_check("sub", 5'd5, 5'd6, 1'b0, 32'd0, 4'b0110);
    chk("sub_dir", result, 32'h0000_0014);

    // async reset mid-run
    @(negedge clk); #2;
    rst = 1'b0; model_clear();
    #1;
    chk("async_rd1", readData1, 32'd0);
    chk("async_rd2", readData2, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    rd_check("post_rst", 5'd5, 5'd6, 1'b0, 32'd0, 4'b0110);

    // x0 write discarded; same-cycle read sees old value
    wr(5'd0, 32'hDEAD_BEEF, 1'b1);
    rd_check("x0", 5'd0, 5'd0, 1'b0, 32'd0, 4'b0001);
    wr(5'd7, 32'h1111_1111, 1'b1);
    @(negedge clk);
    write = 1'b1; writeReg = 5'd7; writeData = 32'h2222_2222; readReg1 = 5'd7;
    #1;
    chk("nobypass_old", readData1, 32'h1111_1111);
    @(posedge clk); #1;
    write = 1'b0; model[7] = 32'h2222_2222;
    chk("nobypass_new", readData1, 32'h2222_2222);

    // shifts
    wr(5'd5, 32'h8000_0000, 1'b1);
    rd_check("sra", 5'd5, 5'd0, 1'b1, 32'd4, 4'b1010);
    chk("sra_dir", result, 32'hF800_0000);
    rd_check("srl", 5'd5, 5'd0, 1'b1, 32'd4, 4'b1000);
    chk("srl_dir", result, 32'h0800_0000);
    rd_check("sll", 5'd5, 5'd0, 1'b1, 32'h21, 4'b1001);
    chk("sll_dir", result, 32'h0000_0000);

    // SLT and logic ops
    wr(5'd8, 32'hFFFF_FFFF, 1'b1);
    wr(5'd9, 32'h0000_0001, 1'b1);
    rd_check("slt", 5'd8, 5'd9, 1'b0, 32'd0, 4'b0111);
    chk("slt_dir", result, 32'd1);
    rd_check("slt_sw", 5'd9, 5'd8, 1'b0, 32'd0, 4'b0111);
    chk("slt_sw_dir", result, 32'd0);
    wr(5'd10, 32'hF0F0_F0F0, 1'b1);
    wr(5'd11, 32'h0FF0_0FF0, 1'b1);
    rd_check("and", 5'd10, 5'd11, 1'b0, 32'd0, 4'b0000);
    chk("and_dir", result, 32'h00F0_00F0);
    rd_check("or", 5'd10, 5'd11, 1'b0, 32'd0, 4'b0001);
    chk("or_dir", result, 32'hFFF0_FFF0);
    rd_check("xor", 5'd10, 5'd11, 1'b0, 32'd0, 4'b1101);
    chk("xor_dir", result, 32'hFF00_FF00);

    // illegal op and write=0
    rd_check("illegal", 5'd10, 5'd11, 1'b0, 32'd0, 4'b1111);
    chk("illegal_zero", {31'd0, zero}, 32'd1);
    wr(5'd10, 32'h5555_5555, 1'b0);
    rd_check("we0", 5'd10, 5'd11, 1'b0, 32'd0, 4'b0001);
    chk("we0_dir", readData1, 32'hF0F0_F0F0);

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      wr(5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 3) != 0));
      rd_check("rand", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom,
               ops[$urandom_range(0, 9)]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
